pid_update_scheduler: RTL

- Sequences the shared multichannel PID core once per fixed control period.
- On each period tick it loads coefficients into the core if a reload is pending, then issues one feedback/reference sample per enabled channel over a valid/ready handshake.
- It then waits until the core reports one result per issued channel.
- Sits between the per-motor rpm measurement blocks, the target-rpm source and the PID core's param/data input ports; replaces free-running start-up sequencing with period-locked, maskable scheduling and error reporting.

---
 rtl/pid_update_scheduler.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/pid_update_scheduler.sv
// pid_update_scheduler
//   Period-locked sequencer for the shared multichannel PID core. Every
//   PERIOD_CYCLES it snapshots measured/target rpm and the channel mask,
//   optionally writes coefficients to all channels, then issues one sample
//   per enabled channel and waits for one result per issued sample.
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   enable_i          : run; low holds the period counter at 0
//   chn_en_i          : per-channel enable mask, sampled at tick
//   cfg_reload_i      : pulse, request coefficient reload at next tick
//   err_clr_i         : pulse, clear overrun_o / timeout_o
//   rpm_ready_i       : per-channel new-measurement strobe
//   rpm_data_i        : packed measured rpm, chn0 in LSBs
//   target_rpm_i      : packed target rpm, chn0 in LSBs
//   coef_i            : packed {min,max,b2,b1,b0,a3,a2,a1}
//   param_valid_o/param_chn_o/param_data_o : coefficient write to core
//   data_valid_o/data_ready_i/data_chn_o/data_fdb_o/data_ref_o : sample to core
//   pid_done_i        : core result strobe
//   busy_o            : not idle
//   frame_done_o      : one-cycle pulse when a frame's results are all back
//   overrun_o         : sticky, tick arrived while busy (tick dropped)
//   timeout_o         : sticky, results did not return in time
//   fsm_state         : current FSM state for debug/checkers
//
// Sample handshake: a sample transfers on a cycle where data_valid_o and
// data_ready_i are both high. While data_valid_o is high and data_ready_i is
// low, data_chn_o/data_fdb_o/data_ref_o stay stable. data_valid_o never
// drops without a transfer.
module pid_update_scheduler #(
   parameter int DATA_WIDTH     = 16,
   parameter int NUM_CHN        = 4,
   parameter int CHN_WIDTH      = 3,
   parameter int PERIOD_CYCLES  = 50000,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          enable_i,
   input  logic [NUM_CHN-1:0]            chn_en_i,
   input  logic                          cfg_reload_i,
   input  logic                          err_clr_i,
   input  logic [NUM_CHN-1:0]            rpm_ready_i,
   input  logic [NUM_CHN*DATA_WIDTH-1:0] rpm_data_i,
   input  logic [NUM_CHN*DATA_WIDTH-1:0] target_rpm_i,
   input  logic [8*DATA_WIDTH-1:0]       coef_i,
   output logic                          param_valid_o,
   output logic [CHN_WIDTH-1:0]          param_chn_o,
   output logic [8*DATA_WIDTH-1:0]       param_data_o,
   output logic                          data_valid_o,
   input  logic                          data_ready_i,
   output logic [CHN_WIDTH-1:0]          data_chn_o,
   output logic [DATA_WIDTH-1:0]         data_fdb_o,
   output logic [DATA_WIDTH-1:0]         data_ref_o,
   input  logic                          pid_done_i,
   output logic                          busy_o,
   output logic                          frame_done_o,
   output logic                          overrun_o,
   output logic                          timeout_o,
   output logic [1:0]                    fsm_state
);

   localparam int CNT_W = $clog2(PERIOD_CYCLES);
   localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
   localparam int NC_W  = $clog2(NUM_CHN + 1);

   typedef enum logic [1:0] {S_IDLE, S_PARAM, S_ISSUE, S_WAIT} state_t;

   state_t state, state_nxt;

   logic [CNT_W-1:0]                     period_cnt;
   logic                                 tick;
   logic                                 start;
   logic [NUM_CHN-1:0][DATA_WIDTH-1:0]   hold;
   logic [NUM_CHN-1:0][DATA_WIDTH-1:0]   snap_rpm;
   logic [NUM_CHN-1:0][DATA_WIDTH-1:0]   snap_tgt;
   logic [NUM_CHN-1:0]                   pend_mask;
   logic [NC_W-1:0]                      n_en;
   logic [NC_W-1:0]                      done_cnt;
   logic [CHN_WIDTH-1:0]                 param_cnt;
   logic [TO_W-1:0]                      wait_cnt;
   logic                                 cfg_pending;
   logic [CHN_WIDTH-1:0]                 sel_chn;
   logic [NUM_CHN-1:0]                   sel_oh;
   logic [DATA_WIDTH-1:0]                sel_fdb;
   logic [DATA_WIDTH-1:0]                sel_ref;
   logic                                 fire;
   logic                                 issue_last;
   logic                                 param_last;
   logic                                 all_done;
   logic                                 timeout_hit;

   function automatic logic [NC_W-1:0] popcount(input logic [NUM_CHN-1:0] m);
      logic [NC_W-1:0] c;
      c = '0;
      for (int k = 0; k < NUM_CHN; k++) c = c + NC_W'(m[k]);
      return c;
   endfunction

   assign tick  = enable_i && (period_cnt == CNT_W'(PERIOD_CYCLES - 1));
   // Only a tick seen in S_IDLE starts a frame; a tick while busy is dropped.
   assign start = tick && (state == S_IDLE);

   assign fire        = (state == S_ISSUE) && data_ready_i;
   assign issue_last  = fire && ((pend_mask & ~sel_oh) == '0);
   assign param_last  = (param_cnt == CHN_WIDTH'(NUM_CHN - 1));
   assign all_done    = (done_cnt >= n_en);
   assign timeout_hit = (state == S_WAIT) && !all_done &&
                        (wait_cnt == TO_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (rst || !enable_i || period_cnt == CNT_W'(PERIOD_CYCLES - 1)) begin
         period_cnt <= '0;
      end else begin
         period_cnt <= period_cnt + 1'b1;
      end
   end

   // Sample-hold, frame snapshot and remaining-channel mask.
   always_ff @(posedge clk) begin
      if (rst) begin
         hold         <= '0;
         snap_rpm     <= '0;
         snap_tgt     <= '0;
         pend_mask    <= '0;
         n_en         <= '0;
         param_data_o <= '0;
      end else begin
         for (int k = 0; k < NUM_CHN; k++) begin
            if (rpm_ready_i[k]) hold[k] <= rpm_data_i[k*DATA_WIDTH +: DATA_WIDTH];
         end
         if (start) begin
            for (int k = 0; k < NUM_CHN; k++) begin
               // A measurement landing on the tick itself bypasses the hold.
               snap_rpm[k] <= rpm_ready_i[k] ? rpm_data_i[k*DATA_WIDTH +: DATA_WIDTH] : hold[k];
               snap_tgt[k] <= target_rpm_i[k*DATA_WIDTH +: DATA_WIDTH];
            end
            pend_mask    <= chn_en_i;
            n_en         <= popcount(chn_en_i);
            param_data_o <= coef_i;
         end else if (fire) begin
            pend_mask <= pend_mask & ~sel_oh;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         param_cnt <= '0;
         wait_cnt  <= '0;
         done_cnt  <= '0;
      end else begin
         param_cnt <= (state == S_PARAM) ? param_cnt + 1'b1 : '0;
         wait_cnt  <= (state == S_WAIT) ? wait_cnt + 1'b1 : '0;
         // Results may start returning while later channels are still issuing.
         if (start) begin
            done_cnt <= '0;
         end else if (pid_done_i && (state == S_ISSUE || state == S_WAIT) && done_cnt != '1) begin
            done_cnt <= done_cnt + 1'b1;
         end
      end
   end

   // A reload request in the last S_PARAM cycle wins, so it is not lost.
   always_ff @(posedge clk) begin
      if (rst) begin
         cfg_pending <= 1'b1;
      end else if (cfg_reload_i) begin
         cfg_pending <= 1'b1;
      end else if (state == S_PARAM && param_last) begin
         cfg_pending <= 1'b0;
      end
   end

   // Sticky errors: a set event beats a simultaneous clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         overrun_o <= 1'b0;
         timeout_o <= 1'b0;
      end else begin
         if (tick && state != S_IDLE) overrun_o <= 1'b1;
         else if (err_clr_i)          overrun_o <= 1'b0;
         if (timeout_hit)             timeout_o <= 1'b1;
         else if (err_clr_i)          timeout_o <= 1'b0;
      end
   end

   // Lowest pending channel of the snapshot mask.
   always_comb begin
      sel_chn = '0;
      sel_oh  = '0;
      sel_fdb = '0;
      sel_ref = '0;
      for (int k = NUM_CHN - 1; k >= 0; k--) begin
         if (pend_mask[k]) begin
            sel_chn    = CHN_WIDTH'(k);
            sel_oh     = '0;
            sel_oh[k]  = 1'b1;
            sel_fdb    = snap_rpm[k];
            sel_ref    = snap_tgt[k];
         end
      end
   end

   // FSM: state register
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // FSM: next state
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (tick && chn_en_i != '0) state_nxt = cfg_pending ? S_PARAM : S_ISSUE;
         S_PARAM: if (param_last) state_nxt = S_ISSUE;
         S_ISSUE: if (issue_last) state_nxt = S_WAIT;
         S_WAIT:  if (all_done || timeout_hit) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // FSM: outputs
   always_comb begin
      param_valid_o = (state == S_PARAM);
      param_chn_o   = (state == S_PARAM) ? param_cnt : '0;
      data_valid_o  = (state == S_ISSUE);
      data_chn_o    = (state == S_ISSUE) ? sel_chn : '0;
      data_fdb_o    = (state == S_ISSUE) ? sel_fdb : '0;
      data_ref_o    = (state == S_ISSUE) ? sel_ref : '0;
      busy_o        = (state != S_IDLE);
      frame_done_o  = (state == S_WAIT) && all_done;
      fsm_state     = state;
   end

endmodule
